// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request/grant bus between byte producers, the arbiter and the UART.
// slave = arbiter side; master = producers plus UART side.
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic                    busy;
  logic                    tx_en;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done;

  modport master (
    output req, req_data, tx_done,
    input  grant, ack, err, busy, tx_en, tx_data
  );

  modport slave (
    input  req, req_data, tx_done,
    output grant, ack, err, busy, tx_en, tx_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter between N_REQ producers,
// with a BUSY watchdog so a UART that never signals tx_done cannot hang the system.
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 60000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [15:0]      CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic                tx_en_q, tx_en_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    owner_q, owner_d;

  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;

  // Scan from farthest to nearest after last, so the nearest requester is written last and wins.
  always_comb begin
    logic [CW-1:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last_q} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (bus.req[cand[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    err_d     = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          tx_data_d        = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
          tx_en_d          = 1'b1;
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // A completion on the same edge as the watchdog expiry counts as success.
        if (bus.tx_done) begin
          ack_d   = grant_q;
          state_d = S_ACK;
        end else if (cnt_q == CNT_LAST) begin
          ack_d   = grant_q;
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACK: begin
        last_d  = owner_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      last_q    <= LAST_RST;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks plus randomized traffic checked against a round-robin model.
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int TO = 20;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   model_last;
  logic [2:0] pend;
  logic [7:0] dat [3];

  uart_tx_arbiter_if #(.N_REQ(3), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.N_REQ(3), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    bus.req      = pend;
    bus.req_data = {dat[2], dat[1], dat[0]};
  endtask

  // Rotating priority: distance after the previous owner, smallest distance wins.
  function automatic int rr_pick(input logic [2:0] p, input int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 99;
    for (int i = 0; i < 3; i++) begin
      if (p[i]) begin
        d = (i - last + 2) % 3;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    reset       = 1'b0;
    pend        = 3'b000;
    bus.tx_done = 1'b0;
    apply();
    tick();
    tick();
    reset      = 1'b1;
    model_last = 2;
  endtask

  // Drives one transfer as requesters plus UART and reports what was observed.
  task automatic do_transfer(input int delay, input bit load_done, input logic [2:0] raise_mask,
                             input bit drop_owner, input bit scramble,
                             output bit found, output int wait_c, output logic [2:0] g,
                             output logic [7:0] d_load, output logic [7:0] d_ack, output int en_cnt,
                             output logic [2:0] ack_v, output logic err_v, output int lat);
    found = 1'b0; wait_c = 0; g = '0; d_load = '0; d_ack = '0;
    en_cnt = 0; ack_v = '0; err_v = 1'b0; lat = 0;
    while (bus.tx_en !== 1'b1 && wait_c < 20) begin
      tick();
      wait_c++;
    end
    if (bus.tx_en !== 1'b1) return;
    found  = 1'b1;
    g      = bus.grant;
    d_load = bus.tx_data;
    en_cnt = 1;
    pend   = pend | raise_mask;
    if (drop_owner) pend = pend & ~g;
    if (scramble) begin
      for (int i = 0; i < 3; i++) if (g[i]) dat[i] = 8'($urandom);
    end
    apply();
    bus.tx_done = load_done;
    while (lat < TO + 10) begin
      tick();
      lat++;
      if (bus.tx_en === 1'b1) en_cnt++;
      if (bus.ack !== 3'b000) begin
        ack_v = bus.ack;
        err_v = bus.err;
        d_ack = bus.tx_data;
        break;
      end
      bus.tx_done = (delay > 0 && lat == delay);
    end
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pend  = 3'b000;
    dat[0] = 8'h00; dat[1] = 8'h00; dat[2] = 8'h00;
    bus.tx_done = 1'b0;
    apply();
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.grant, bus.ack, bus.err, bus.busy, bus.tx_en, bus.tx_data} !== 17'd0)
      $display("FAIL reset_outputs got=%h exp=0", {bus.grant, bus.ack, bus.err, bus.busy, bus.tx_en, bus.tx_data});
    else n_pass++;
    pend = 3'b111;
    apply();
    tick();
    tick();
    n_total++;
    if ({bus.grant, bus.busy, bus.tx_en} !== 5'd0)
      $display("FAIL reset_held got=%b exp=0", {bus.grant, bus.busy, bus.tx_en});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    bit found; int wc, en, lat; logic [2:0] g, a; logic [7:0] dl, da; logic e;
    do_reset();
    dat[0] = 8'hA5;
    pend   = 3'b001;
    apply();
    do_transfer(10, 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    pend = 3'b000;
    apply();
    n_total++; if (wc !== 1)        $display("FAIL single_latency got=%0d exp=1", wc);        else n_pass++;
    n_total++; if (g !== 3'b001)    $display("FAIL single_grant got=%b exp=001", g);          else n_pass++;
    n_total++; if (dl !== 8'hA5)    $display("FAIL single_data got=%h exp=a5", dl);           else n_pass++;
    n_total++; if (en !== 1)        $display("FAIL single_txen got=%0d exp=1", en);           else n_pass++;
    n_total++; if (a !== 3'b001)    $display("FAIL single_ack got=%b exp=001", a);            else n_pass++;
    n_total++; if (e !== 1'b0)      $display("FAIL single_err got=%b exp=0", e);              else n_pass++;
    n_total++; if (lat !== 11)      $display("FAIL single_ack_time got=%0d exp=11", lat);     else n_pass++;
    tick();
    n_total++; if (bus.busy !== 1'b0 || bus.grant !== 3'b000)
      $display("FAIL single_idle busy=%b grant=%b exp=0/000", bus.busy, bus.grant); else n_pass++;
    model_last = 0;
  endtask

  task automatic test_simultaneous();
    bit found; int wc, en, lat, total_en, exp; logic [2:0] g, a; logic [7:0] dl, da; logic e;
    logic [7:0] exp_bytes [3];
    do_reset();
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    pend = 3'b111;
    apply();
    total_en = 0;
    for (int t = 0; t < 3; t++) begin
      exp = rr_pick(pend, model_last);
      do_transfer(int'($urandom_range(1, 5)), 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
      if (exp >= 0) pend[exp] = 1'b0;
      apply();
      total_en += en;
      n_total++; if (dl !== exp_bytes[t]) $display("FAIL simul_order t=%0d got=%h exp=%h", t, dl, exp_bytes[t]); else n_pass++;
      n_total++; if (a !== (3'b001 << exp)) $display("FAIL simul_ack t=%0d got=%b exp=%b", t, a, 3'b001 << exp); else n_pass++;
      if (t > 0) begin
        n_total++; if (wc !== 2) $display("FAIL simul_gap t=%0d got=%0d exp=2", t, wc); else n_pass++;
      end
      model_last = exp;
    end
    n_total++; if (total_en !== 3) $display("FAIL simul_txen_count got=%0d exp=3", total_en); else n_pass++;
  endtask

  task automatic test_fairness();
    bit found; int wc, en, lat; logic [2:0] g, a; logic [7:0] dl, da; logic e;
    logic [2:0] seen [3];
    do_reset();
    dat[0] = 8'h5A; dat[1] = 8'hC3;
    pend = 3'b001;
    apply();
    do_transfer(3, 1'b0, 3'b010, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    seen[0] = g;
    do_transfer(2, 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    seen[1] = g;
    pend[1] = 1'b0;
    apply();
    n_total++; if (dl !== 8'hC3) $display("FAIL fair_data1 got=%h exp=c3", dl); else n_pass++;
    do_transfer(2, 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    seen[2] = g;
    pend = 3'b000;
    apply();
    n_total++; if (seen[0] !== 3'b001) $display("FAIL fair_grant0 got=%b exp=001", seen[0]); else n_pass++;
    n_total++; if (seen[1] !== 3'b010) $display("FAIL fair_grant1 got=%b exp=010", seen[1]); else n_pass++;
    n_total++; if (seen[2] !== 3'b001) $display("FAIL fair_grant2 got=%b exp=001", seen[2]); else n_pass++;
    tick();
    model_last = 0;
  endtask

  task automatic test_timeout();
    bit found; int wc, en, lat; logic [2:0] g, a; logic [7:0] dl, da; logic e;
    do_reset();
    dat[2] = 8'h7E;
    pend = 3'b100;
    apply();
    do_transfer(0, 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    pend = 3'b000;
    apply();
    n_total++; if (a !== 3'b100)  $display("FAIL timeout_ack got=%b exp=100", a); else n_pass++;
    n_total++; if (e !== 1'b1)    $display("FAIL timeout_err got=%b exp=1", e); else n_pass++;
    n_total++; if (lat !== TO + 1) $display("FAIL timeout_time got=%0d exp=%0d", lat, TO + 1); else n_pass++;
    tick();
    n_total++; if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.ack !== 3'b000)
      $display("FAIL timeout_idle busy=%b err=%b ack=%b exp=0", bus.busy, bus.err, bus.ack); else n_pass++;
    model_last = 2;
  endtask

  task automatic test_spurious_done();
    bit found; int wc, en, lat; logic [2:0] g, a; logic [7:0] dl, da; logic e;
    do_reset();
    bus.tx_done = 1'b1;
    tick();
    tick();
    bus.tx_done = 1'b0;
    n_total++; if ({bus.busy, bus.ack, bus.err, bus.tx_en} !== 6'd0)
      $display("FAIL spur_idle got=%b exp=0", {bus.busy, bus.ack, bus.err, bus.tx_en}); else n_pass++;
    dat[1] = 8'h3C;
    pend = 3'b010;
    apply();
    do_transfer(3, 1'b1, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    pend = 3'b000;
    apply();
    n_total++; if (lat !== 4)     $display("FAIL spur_load_ignored got=%0d exp=4", lat); else n_pass++;
    n_total++; if (a !== 3'b010)  $display("FAIL spur_ack got=%b exp=010", a); else n_pass++;
    tick();
    dat[0] = 8'h99;
    pend = 3'b001;
    apply();
    do_transfer(TO, 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    pend = 3'b000;
    apply();
    n_total++; if (e !== 1'b0)     $display("FAIL coincide_err got=%b exp=0", e); else n_pass++;
    n_total++; if (a !== 3'b001)   $display("FAIL coincide_ack got=%b exp=001", a); else n_pass++;
    n_total++; if (lat !== TO + 1) $display("FAIL coincide_time got=%0d exp=%0d", lat, TO + 1); else n_pass++;
    tick();
    model_last = 0;
  endtask

  task automatic test_reset_mid_busy();
    bit found; int wc, en, lat; logic [2:0] g, a; logic [7:0] dl, da; logic e;
    logic saw_ack;
    do_reset();
    dat[0] = 8'hE1;
    pend = 3'b001;
    apply();
    tick();
    tick();
    tick();
    tick();
    n_total++; if (bus.busy !== 1'b1 || bus.grant !== 3'b001)
      $display("FAIL midrst_busy busy=%b grant=%b exp=1/001", bus.busy, bus.grant); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.grant, bus.ack, bus.err, bus.busy, bus.tx_en, bus.tx_data} !== 17'd0)
      $display("FAIL midrst_async got=%h exp=0", {bus.grant, bus.ack, bus.err, bus.busy, bus.tx_en, bus.tx_data});
    else n_pass++;
    @(posedge clk);
    #1;
    saw_ack = (bus.ack !== 3'b000);
    reset = 1'b1;
    model_last = 2;
    tick();
    saw_ack = saw_ack | (bus.ack !== 3'b000);
    n_total++; if (saw_ack !== 1'b0) $display("FAIL midrst_no_ack got=%b exp=0", saw_ack); else n_pass++;
    do_transfer(2, 1'b0, 3'b000, 1'b0, 1'b0, found, wc, g, dl, da, en, a, e, lat);
    pend = 3'b000;
    apply();
    n_total++; if (g !== 3'b001)  $display("FAIL midrst_regrant got=%b exp=001", g); else n_pass++;
    n_total++; if (dl !== 8'hE1)  $display("FAIL midrst_data got=%h exp=e1", dl); else n_pass++;
    tick();
    model_last = 0;
  endtask

  task automatic test_random();
    bit found; int wc, en, lat, exp, delay, r; logic [2:0] g, a, newm; logic [7:0] dl, da, exp_d; logic e;
    bit drop, scr;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      newm = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) if (newm[i] && !pend[i]) dat[i] = 8'($urandom);
      pend = pend | newm;
      if (pend == 3'b000) pend[$urandom_range(0, 2)] = 1'b1;
      apply();
      exp   = rr_pick(pend, model_last);
      exp_d = dat[exp];
      r     = int'($urandom_range(0, 9));
      delay = r;
      drop  = ($urandom_range(0, 3) == 0);
      scr   = ($urandom_range(0, 2) == 0);
      do_transfer(delay, 1'b0, 3'b000, drop, scr, found, wc, g, dl, da, en, a, e, lat);
      n_total++; if (found !== 1'b1)         $display("FAIL rand_start it=%0d got=%b exp=1", it, found); else n_pass++;
      n_total++; if (g !== (3'b001 << exp))  $display("FAIL rand_grant it=%0d got=%b exp=%b", it, g, 3'b001 << exp); else n_pass++;
      n_total++; if (dl !== exp_d)           $display("FAIL rand_data it=%0d got=%h exp=%h", it, dl, exp_d); else n_pass++;
      n_total++; if (da !== exp_d)           $display("FAIL rand_data_hold it=%0d got=%h exp=%h", it, da, exp_d); else n_pass++;
      n_total++; if (a !== (3'b001 << exp))  $display("FAIL rand_ack it=%0d got=%b exp=%b", it, a, 3'b001 << exp); else n_pass++;
      n_total++; if (e !== (delay == 0))     $display("FAIL rand_err it=%0d got=%b exp=%b", it, e, delay == 0); else n_pass++;
      n_total++; if (lat !== ((delay == 0) ? TO + 1 : delay + 1))
        $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, (delay == 0) ? TO + 1 : delay + 1); else n_pass++;
      n_total++; if (en !== 1)               $display("FAIL rand_txen it=%0d got=%0d exp=1", it, en); else n_pass++;
      model_last = exp;
      if (!drop && $urandom_range(0, 2) != 0) pend[exp] = 1'b0;
      apply();
    end
    pend = 3'b000;
    apply();
    tick();
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_last = 2;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_spurious_done();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
